mdu_div: RTL and testbench

Iterative radix-2 restoring divider serving the execute-stage multiply/divide unit. The MDU issues DIV/DIVU operands to this block and takes the quotient into LO and the remainder into HI when `done` pulses. It replaces the single-cycle behavioural division with a fixed-latency, synthesizable datapath. The MDU's hazard logic tracks its busy window from this block's `busy`/`done`.

---
 rtl/mdu_div_pkg.sv | 13 +
 rtl/mdu_div_div_step.sv | 16 +
 rtl/mdu_div.sv | 110 +++++++++++
 tb/tb_mdu_div.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_div_pkg.sv
// mdu_div_pkg: shared state encodings and latency constants for the iterative divider
package mdu_div_pkg;
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ITER = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;
    localparam int DIV_ITERS = 32;
    localparam int DIV_LATENCY = 33;
    function automatic logic [31:0] mag(input logic sg, input logic [31:0] v);
        return (sg && v[31]) ? -v : v;
    endfunction
endpackage

// File: rtl/mdu_div_div_step.sv
// div_step: one combinational restoring-division step on a 33-bit shifted partial remainder
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_sh,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_nx,
    output logic             qbit
);
    logic [WIDTH+1:0] diff;
    always_comb begin
        diff = {1'b0, rem_sh} - {2'b00, dvs};
        qbit = ~diff[WIDTH+1];
        rem_nx = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    end
endmodule

// File: rtl/mdu_div.sv
// mdu_div: 33-cycle radix-2 restoring DIV/DIVU; MDU_DIV_ZERO_FAST_EN short-circuits zero divisors
module mdu_div
    import mdu_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div0
);
    if (WIDTH != 32) begin : g_bad_width
        $error("mdu_div supports WIDTH == 32 only");
    end
    div_state_t       state;
    logic [4:0]       cnt;
    logic [WIDTH-1:0] pr, dq, dvs, raw;
    logic             neg_q, neg_r, z;
    logic [WIDTH-1:0] rem_nx, q_fin, q_out, r_out;
    logic             qbit;
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_sh (({pr, dq[WIDTH-1]})),
        .dvs    (dvs),
        .rem_nx (rem_nx),
        .qbit   (qbit)
    );
    always_comb begin
        q_fin = {dq[WIDTH-2:0], qbit};
        q_out = z ? '1 : neg_q ? -q_fin : q_fin;
        r_out = z ? raw : neg_r ? -rem_nx : rem_nx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
            cnt <= '0;
            pr <= '0;
            dq <= '0;
            dvs <= '0;
            raw <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            z <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            quot <= '0;
            rem <= '0;
            div0 <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    done <= 1'b0;
                    if (start && !cancel) begin
                        neg_q <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r <= sign & dividend[WIDTH-1];
                        dq <= mag(sign, dividend);
                        dvs <= mag(sign, divisor);
                        raw <= dividend;
                        z <= divisor == '0;
                        pr <= '0;
                        cnt <= 5'(DIV_ITERS - 1);
`ifdef MDU_DIV_ZERO_FAST_EN
                        if (divisor == '0) begin
                            state <= DIV_DONE;
                            done <= 1'b1;
                            div0 <= 1'b1;
                        end else begin
                            state <= DIV_ITER;
                            busy <= 1'b1;
                        end
`else
                        state <= DIV_ITER;
                        busy <= 1'b1;
`endif
                    end
                end
                DIV_ITER: begin
                    if (cancel) begin
                        state <= DIV_IDLE;
                        busy <= 1'b0;
                    end else begin
                        pr <= rem_nx;
                        dq <= q_fin;
                        cnt <= cnt - 5'd1;
                        // results land on the edge entering DONE so they are visible with done
                        if (cnt == 5'd0) begin
                            state <= DIV_DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                            quot <= q_out;
                            rem <= r_out;
                            div0 <= z;
                        end
                    end
                end
                default: begin
                    state <= DIV_IDLE;
                    done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_div.sv
// tb_mdu_div: directed self-checking bench for mdu_div
module tb_mdu_div;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sign = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        cancel = 1'b0;
    logic        busy, done, div0;
    logic [31:0] quot, rem;
    int n_cmp = 0;
    int n_err = 0;
    int lat, bc;

    mdu_div #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .sign(sign),
        .dividend(dividend), .divisor(divisor), .cancel(cancel),
        .busy(busy), .done(done), .quot(quot), .rem(rem), .div0(div0)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b);
        sign = sg;
        dividend = a;
        divisor = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // lat counts cycles after the accepting edge; done expected at lat == 33
    task automatic wait_done(input int l0, output int l, output int b);
        l = l0;
        b = 0;
        while (!done && l < 100) begin
            if (busy) b++;
            step();
            l++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b expected 0", done); end
        n_cmp++; if ({quot, rem} !== 64'd0) begin n_err++; $display("FAIL reset quot/rem: got %h/%h expected 0/0", quot, rem); end
        n_cmp++; if (div0 !== 1'b0) begin n_err++; $display("FAIL reset div0: got %b expected 0", div0); end
    endtask

    task automatic test_unsigned();
        issue(1'b0, 32'd100, 32'd7);
        wait_done(1, lat, bc);
        n_cmp++; if (lat != 33) begin n_err++; $display("FAIL unsigned latency: got %0d expected 33", lat); end
        n_cmp++; if (bc != 32) begin n_err++; $display("FAIL unsigned busy cycles: got %0d expected 32", bc); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL unsigned busy at done: got %b expected 0", busy); end
        n_cmp++; if (quot !== 32'd14) begin n_err++; $display("FAIL unsigned quot: got %h expected %h", quot, 32'd14); end
        n_cmp++; if (rem !== 32'd2) begin n_err++; $display("FAIL unsigned rem: got %h expected %h", rem, 32'd2); end
        n_cmp++; if (div0 !== 1'b0) begin n_err++; $display("FAIL unsigned div0: got %b expected 0", div0); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL unsigned done pulse width: got %b expected 0", done); end
        n_cmp++; if (quot !== 32'd14) begin n_err++; $display("FAIL unsigned quot hold: got %h expected %h", quot, 32'd14); end
    endtask

    task automatic test_signed();
        issue(1'b1, 32'hFFFFFFF9, 32'd2);
        wait_done(1, lat, bc);
        n_cmp++; if (quot !== 32'hFFFFFFFD) begin n_err++; $display("FAIL signed -7/2 quot: got %h expected FFFFFFFD", quot); end
        n_cmp++; if (rem !== 32'hFFFFFFFF) begin n_err++; $display("FAIL signed -7/2 rem: got %h expected FFFFFFFF", rem); end
        step();
        issue(1'b1, 32'd7, 32'hFFFFFFFE);
        wait_done(1, lat, bc);
        n_cmp++; if (quot !== 32'hFFFFFFFD) begin n_err++; $display("FAIL signed 7/-2 quot: got %h expected FFFFFFFD", quot); end
        n_cmp++; if (rem !== 32'd1) begin n_err++; $display("FAIL signed 7/-2 rem: got %h expected 00000001", rem); end
        step();
    endtask

    task automatic test_extremes();
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_done(1, lat, bc);
        n_cmp++; if (quot !== 32'h80000000) begin n_err++; $display("FAIL signed overflow quot: got %h expected 80000000", quot); end
        n_cmp++; if (rem !== 32'd0) begin n_err++; $display("FAIL signed overflow rem: got %h expected 00000000", rem); end
        step();
        issue(1'b0, 32'h80000000, 32'hFFFFFFFF);
        wait_done(1, lat, bc);
        n_cmp++; if (quot !== 32'd0) begin n_err++; $display("FAIL unsigned extreme quot: got %h expected 00000000", quot); end
        n_cmp++; if (rem !== 32'h80000000) begin n_err++; $display("FAIL unsigned extreme rem: got %h expected 80000000", rem); end
        step();
    endtask

    task automatic test_div0();
        issue(1'b0, 32'h1234, 32'd0);
        wait_done(1, lat, bc);
        n_cmp++; if (div0 !== 1'b1) begin n_err++; $display("FAIL div0 flag: got %b expected 1", div0); end
`ifdef MDU_DIV_ZERO_FAST_EN
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL div0 fast latency: got %0d expected 1", lat); end
        n_cmp++; if (bc != 0) begin n_err++; $display("FAIL div0 fast busy cycles: got %0d expected 0", bc); end
        n_cmp++; if (quot !== 32'd0) begin n_err++; $display("FAIL div0 fast quot kept: got %h expected 00000000", quot); end
        n_cmp++; if (rem !== 32'h80000000) begin n_err++; $display("FAIL div0 fast rem kept: got %h expected 80000000", rem); end
`else
        n_cmp++; if (lat != 33) begin n_err++; $display("FAIL div0 latency: got %0d expected 33", lat); end
        n_cmp++; if (quot !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div0 quot: got %h expected FFFFFFFF", quot); end
        n_cmp++; if (rem !== 32'h1234) begin n_err++; $display("FAIL div0 rem: got %h expected 00001234", rem); end
`endif
        step();
        issue(1'b0, 32'd9, 32'd3);
        wait_done(1, lat, bc);
        n_cmp++; if (div0 !== 1'b0) begin n_err++; $display("FAIL div0 clear: got %b expected 0", div0); end
        n_cmp++; if (quot !== 32'd3) begin n_err++; $display("FAIL div0 follow quot: got %h expected 00000003", quot); end
        step();
    endtask

    task automatic test_abort();
        int seen;
        issue(1'b0, 32'd100, 32'd7);
        repeat (9) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cancel busy: got %b expected 0", busy); end
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            step();
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL cancel done: got %0d pulses expected 0", seen); end
        n_cmp++; if ({quot, rem} !== {32'd3, 32'd0}) begin n_err++; $display("FAIL cancel retain: got %h/%h expected 00000003/00000000", quot, rem); end
        sign = 1'b0; dividend = 32'd100; divisor = 32'd7;
        start = 1'b1; cancel = 1'b1;
        step();
        start = 1'b0; cancel = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cancel beats start: got busy %b expected 0", busy); end
        issue(1'b0, 32'd100, 32'd7);
        repeat (19) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if ({busy, done, div0} !== 3'b000) begin n_err++; $display("FAIL abort rst flags: got %b expected 000", {busy, done, div0}); end
        n_cmp++; if ({quot, rem} !== 64'd0) begin n_err++; $display("FAIL abort rst outputs: got %h/%h expected 0/0", quot, rem); end
        issue(1'b0, 32'd9, 32'd3);
        wait_done(1, lat, bc);
        n_cmp++; if ({quot, rem} !== {32'd3, 32'd0}) begin n_err++; $display("FAIL after abort 9/3: got %h/%h expected 00000003/00000000", quot, rem); end
        n_cmp++; if (lat != 33) begin n_err++; $display("FAIL after abort latency: got %0d expected 33", lat); end
        step();
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 32'd100, 32'd7);
        repeat (4) step();
        dividend = 32'd9; divisor = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(6, lat, bc);
        n_cmp++; if (lat != 33) begin n_err++; $display("FAIL b2b first latency: got %0d expected 33", lat); end
        n_cmp++; if (quot !== 32'd14) begin n_err++; $display("FAIL b2b busy start ignored: got %h expected 0000000E", quot); end
        dividend = 32'd9; divisor = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b start in DONE: got busy %b expected 0", busy); end
        issue(1'b0, 32'd200, 32'd10);
        wait_done(1, lat, bc);
        n_cmp++; if (lat != 33) begin n_err++; $display("FAIL b2b second latency: got %0d expected 33", lat); end
        n_cmp++; if ({quot, rem} !== {32'd20, 32'd0}) begin n_err++; $display("FAIL b2b second result: got %h/%h expected 00000014/00000000", quot, rem); end
        step();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_extremes();
        test_div0();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
